goertzel_coeff_server: RTL and testbench
========================================

// Module: goertzel_coeff_server
// PURPOSE
//  Responder side of the Goertzel trig-coefficient handshake (request_trig / trig_ready / sin / cos).
//  - Each request returns sin and cos of 2*pi*k/NUM_SAMPLES for the next bin index k of a programmable sweep.
//  - Values come from one quarter-wave sine ROM using quadrant symmetry.
//  - Sits beside the Goertzel manager, which consumes one coefficient pair per DSP lane per run.
// PARAMETERS
//  NUM_SAMPLES  512  block length N; power of two, >= 8
//  NS_BITS      9    log2(NUM_SAMPLES); width of bin index
//  C_W          16   coefficient width, signed Q1.14 (+1.0 = 16'h4000)
//  ROM_FILE     "quarter_sine_q14.hex"  init file: N/4+1 entries, sin(2*pi*i/N), i=0..N/4
// PORTS
//  sys_clk        in   1        system clock, all logic posedge
//  sys_rst        in   1        synchronous reset, active-high
//  request_trig   in   1        coefficient request; rising edge = one request (level may last 1-2 cycles)
//  trig_ready     out  1        1-cycle pulse; sin_out/cos_out valid in this cycle
//  sin_out        out  C_W      signed Q1.14 sin(2*pi*k/N), held until next trig_ready
//  cos_out        out  C_W      signed Q1.14 cos(2*pi*k/N), held until next trig_ready
//  bin_start      in   NS_BITS  first bin index of sweep
//  bin_step       in   NS_BITS  index increment per served request (mod N)
//  num_coeffs     in   6        coefficients per sweep; 0 behaves as 1
//  sweep_restart  in   1        1-cycle pulse: next request serves bin_start
//  sweep_done     out  1        1-cycle pulse, coincident with trig_ready of last coefficient of sweep
//  req_overrun    out  1        sticky; set when a request edge arrives with one already pending; cleared by reset
// BEHAVIOUR
//  Reset: trig_ready=0, sin_out=0, cos_out=0, sweep_done=0, req_overrun=0.
//    Internal: state=IDLE, k=bin_start, coeff_ctr=0, pending=0, req_d=0.
//  Request detect: req_edge = request_trig & ~req_d. req_d is a register.
//  FSM: IDLE -> S_ADDR -> S_DATA -> C_ADDR -> C_DATA -> PRESENT -> IDLE.
//    IDLE: leave on req_edge or pending; clear pending.
//    S_ADDR: drive sin ROM address for k.
//    S_DATA: capture sin word.
//    C_ADDR: drive address for p = (k + N/4) mod N, since cos(k) = sin(k+N/4).
//    C_DATA: capture cos word.
//    PRESENT: update sin_out/cos_out; pulse trig_ready.
//  Latency: trig_ready is high exactly 5 cycles after the cycle in which req_edge is sampled.
//  Busy requests: req_edge in any non-IDLE state sets pending (one deep).
//    A pending request is served immediately after PRESENT; a second edge while pending sets req_overrun.
//  Quadrant map, p in [0,N): q = p[NS_BITS-1:NS_BITS-2], r = p[NS_BITS-3:0], T = ROM.
//    q0 -> +T[r], q1 -> +T[N/4-r], q2 -> -T[r], q3 -> -T[N/4-r].
//    ROM address is NS_BITS-1 bits wide (0..N/4). Negation is two's complement; no saturation needed (|T| <= 16'h4000).
//  Sweep: in PRESENT, coeff_ctr += 1 and k = (k + bin_step) mod N (natural wrap).
//    If coeff_ctr+1 >= max(num_coeffs,1): sweep_done=1, coeff_ctr=0, k=bin_start.
//  sweep_restart: k=bin_start, coeff_ctr=0; no output change.
//    In non-IDLE states it takes effect after the in-flight request; that request uses the old k.
//    Coincident with PRESENT: restart wins over the sweep advance.
//  Config inputs (bin_start, bin_step, num_coeffs) are sampled only on reset, restart, or wrap.
//  Reset mid-request: request is abandoned; no trig_ready is produced.
// STRUCTURE
//  Shared package/header: Q1.14 constants (ONE_Q14 = 16'h4000), FSM state encodings.
//  Sub-module quarter_sine_rom: synchronous read, 1-cycle latency, single port.
//    Contents loaded via $readmemh(ROM_FILE), N/4+1 x C_W; maps to EBR.
//  Top: FSM, quadrant mapper, sweep counter, request edge/pending logic.
// TESTING (N=512)
//  bin_start=0, one request -> trig_ready 5 cycles later: sin_out=0, cos_out=16384.
//  bin_start=128 -> sin=16384, cos=0.
//  bin_start=256 -> sin=0, cos=-16384.
//  bin_start=64 -> sin=cos=11585; bin_start=448 -> sin=-11585, cos=11585.
//  start=10, step=3, num_coeffs=4, 5 requests -> k=10,13,16,19,10; sweep_done on 4th trig_ready only.
//  Two request edges 2 cycles apart -> two trig_ready pulses at +5 and +10; third edge while busy+pending -> req_overrun=1.
//  sys_rst asserted in S_DATA -> no trig_ready; all outputs 0; next request serves bin_start.
//  Self-checking bench sweeps all 512 bins against a real-valued model, tolerance 1 LSB.

Source files
------------

// File: rtl/goertzel_coeff_server_pkg.sv
// Shared definitions for the Goertzel coefficient server.
//  - ONE_Q14   : +1.0 in signed Q1.14
//  - state_e   : responder FSM encoding (also visible on dbg_state)
//  - qsin_q14  : elaboration-time sine generator for the quarter-wave ROM,
//                sin(2*pi*idx/n) rounded to Q1.14, computed with an integer
//                Taylor series in Q28 so no external init file is needed.
package goertzel_coeff_server_pkg;

  localparam logic [15:0] ONE_Q14 = 16'h4000;

  // round(pi * 2^28)
  localparam longint PI_Q28 = 64'sd843314857;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_S_ADDR  = 3'd1,
    ST_S_DATA  = 3'd2,
    ST_C_ADDR  = 3'd3,
    ST_C_DATA  = 3'd4,
    ST_PRESENT = 3'd5
  } state_e;

  // Only evaluated for idx in [0, n/4], i.e. angles in [0, pi/2], where the
  // series converges quickly; nine terms leave error far below 2^-14.
  function automatic longint qsin_q14(input int idx, input int n);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = (2 * PI_Q28 * longint'(idx)) / longint'(n);
    x2   = (x * x) >>> 28;
    term = x;
    sum  = x;
    for (int t = 1; t <= 9; t++) begin
      term = -((term * x2) >>> 28) / longint'((2 * t) * (2 * t + 1));
      sum  = sum + term;
    end
    return (sum * longint'(ONE_Q14) + (64'sd1 <<< 27)) >>> 28;
  endfunction

endpackage

// File: rtl/goertzel_coeff_server_quarter_sine_rom.sv
// Quarter-wave sine ROM.
//  Holds NUM_SAMPLES/4+1 words: sin(2*pi*i/N) in Q1.14 for i = 0..N/4.
//  Synchronous single-port read, one cycle of latency (EBR friendly).
// Ports
//  clk_i   in   1          clock
//  addr_i  in   NS_BITS-1  word address, 0..N/4
//  data_o  out  C_W        registered ROM word
module quarter_sine_rom
  import goertzel_coeff_server_pkg::*;
#(
  parameter int NUM_SAMPLES = 512,
  parameter int NS_BITS     = 9,
  parameter int C_W         = 16
) (
  input  logic               clk_i,
  input  logic [NS_BITS-2:0] addr_i,
  output logic [C_W-1:0]     data_o
);

  localparam int DEPTH = NUM_SAMPLES / 4 + 1;

  logic [C_W-1:0] rom [0:DEPTH-1];
  logic [C_W-1:0] data_q;

  // Contents are constants fixed at elaboration.
  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam longint VAL = qsin_q14(g, NUM_SAMPLES);
    assign rom[g] = C_W'(VAL);
  end

  always_ff @(posedge clk_i) begin
    data_q <= rom[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/goertzel_coeff_server.sv
// Goertzel trig-coefficient server (responder side of request_trig/trig_ready).
//  Each request returns sin/cos of 2*pi*k/N for the current bin k of a
//  programmable sweep, read from a single quarter-wave sine ROM using
//  quadrant symmetry (cos(k) = sin(k + N/4)).
//
// Handshake: a rising edge on request_trig is one request. trig_ready is a
//  one-cycle pulse exactly 5 cycles after the cycle in which the edge is
//  seen; sin_out/cos_out are valid in that cycle and held until the next
//  pulse. An edge arriving while busy is queued one deep; an edge arriving
//  while one is already queued sets the sticky req_overrun flag.
//
// Ports
//  sys_clk, sys_rst        clock, synchronous active-high reset
//  request_trig            request level (rising edge = request)
//  trig_ready              result-valid pulse
//  sin_out, cos_out        signed Q1.14 results
//  bin_start, bin_step     sweep start bin and per-request increment (mod N)
//  num_coeffs              coefficients per sweep, 0 behaves as 1
//  sweep_restart           pulse: next request serves bin_start
//  sweep_done              pulse with trig_ready of the last coefficient
//  req_overrun             sticky request-overrun flag
//  dbg_state               current FSM state (state_e encoding)
module goertzel_coeff_server
  import goertzel_coeff_server_pkg::*;
#(
  parameter int NUM_SAMPLES = 512,
  parameter int NS_BITS     = 9,
  parameter int C_W         = 16
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               request_trig,
  output logic               trig_ready,
  output logic [C_W-1:0]     sin_out,
  output logic [C_W-1:0]     cos_out,
  input  logic [NS_BITS-1:0] bin_start,
  input  logic [NS_BITS-1:0] bin_step,
  input  logic [5:0]         num_coeffs,
  input  logic               sweep_restart,
  output logic               sweep_done,
  output logic               req_overrun,
  output logic [2:0]         dbg_state
);

  localparam logic [NS_BITS-1:0] QUARTER   = NS_BITS'(NUM_SAMPLES / 4);
  localparam logic [NS_BITS-2:0] QUARTER_A = (NS_BITS - 1)'(NUM_SAMPLES / 4);

  state_e             state_q;
  logic               req_d_q;
  logic               pending_q;
  logic               restart_pend_q;
  logic [NS_BITS-1:0] k_q;
  logic [5:0]         ctr_q;
  logic [NS_BITS-1:0] step_cfg_q;
  logic [5:0]         num_cfg_q;
  logic [C_W-1:0]     sin_word_q;
  logic [1:0]         quad_q;
  logic               trig_q;
  logic [C_W-1:0]     sin_out_q;
  logic [C_W-1:0]     cos_out_q;
  logic               done_q;
  logic               overrun_q;

  logic               req_edge;
  logic               restart_now;
  logic [NS_BITS-1:0] phase;
  logic [1:0]         quad;
  logic [NS_BITS-3:0] rem;
  logic [NS_BITS-2:0] rom_addr;
  logic [C_W-1:0]     rom_data;
  logic [C_W-1:0]     mapped;
  logic [5:0]         num_eff;
  logic               last;

  assign req_edge    = request_trig & ~req_d_q;
  assign restart_now = sweep_restart | restart_pend_q;

  // Quadrant mapper. The phase is k for the sin read and k+N/4 for the cos
  // read; odd quadrants mirror the table, upper half-cycle negates it. The
  // quadrant is registered alongside the ROM's own address register so the
  // sign is applied to the matching data word one cycle later.
  assign phase    = (state_q == ST_C_ADDR) ? (k_q + QUARTER) : k_q;
  assign quad     = phase[NS_BITS-1 -: 2];
  assign rem      = phase[NS_BITS-3:0];
  assign rom_addr = quad[0] ? (QUARTER_A - {1'b0, rem}) : {1'b0, rem};
  assign mapped   = quad_q[1] ? (-rom_data) : rom_data;

  assign num_eff = (num_cfg_q == 6'd0) ? 6'd1 : num_cfg_q;
  assign last    = ({1'b0, ctr_q} + 7'd1) >= {1'b0, num_eff};

  quarter_sine_rom #(
    .NUM_SAMPLES (NUM_SAMPLES),
    .NS_BITS     (NS_BITS),
    .C_W         (C_W)
  ) u_rom (
    .clk_i  (sys_clk),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= ST_IDLE;
      req_d_q        <= 1'b0;
      pending_q      <= 1'b0;
      restart_pend_q <= 1'b0;
      k_q            <= bin_start;
      ctr_q          <= 6'd0;
      step_cfg_q     <= bin_step;
      num_cfg_q      <= num_coeffs;
      sin_word_q     <= '0;
      quad_q         <= 2'd0;
      trig_q         <= 1'b0;
      sin_out_q      <= '0;
      cos_out_q      <= '0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      req_d_q <= request_trig;
      quad_q  <= quad;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (restart_now) begin
            k_q            <= bin_start;
            ctr_q          <= 6'd0;
            step_cfg_q     <= bin_step;
            num_cfg_q      <= num_coeffs;
            restart_pend_q <= 1'b0;
          end
          if (req_edge || pending_q) begin
            state_q   <= ST_S_ADDR;
            pending_q <= 1'b0;
          end
        end
        ST_S_ADDR: state_q <= ST_S_DATA;
        ST_S_DATA: begin
          sin_word_q <= mapped;
          state_q    <= ST_C_ADDR;
        end
        ST_C_ADDR: state_q <= ST_C_DATA;
        ST_C_DATA: begin
          // Outputs are loaded here so they are visible during PRESENT.
          sin_out_q <= sin_word_q;
          cos_out_q <= mapped;
          trig_q    <= 1'b1;
          done_q    <= last;
          state_q   <= ST_PRESENT;
        end
        ST_PRESENT: begin
          // A restart (live or deferred) overrides the sweep advance.
          if (restart_now) begin
            k_q            <= bin_start;
            ctr_q          <= 6'd0;
            step_cfg_q     <= bin_step;
            num_cfg_q      <= num_coeffs;
            restart_pend_q <= 1'b0;
          end else if (last) begin
            k_q        <= bin_start;
            ctr_q      <= 6'd0;
            step_cfg_q <= bin_step;
            num_cfg_q  <= num_coeffs;
          end else begin
            k_q   <= k_q + step_cfg_q;
            ctr_q <= ctr_q + 6'd1;
          end
          // A queued (or just-arrived) request starts without visiting IDLE.
          if (req_edge && pending_q) begin
            overrun_q <= 1'b1;
          end
          state_q   <= (req_edge || pending_q) ? ST_S_ADDR : ST_IDLE;
          pending_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase

      // Requests and restarts arriving mid-request are deferred.
      if (state_q != ST_IDLE && state_q != ST_PRESENT) begin
        if (sweep_restart) begin
          restart_pend_q <= 1'b1;
        end
        if (req_edge) begin
          if (pending_q) begin
            overrun_q <= 1'b1;
          end else begin
            pending_q <= 1'b1;
          end
        end
      end
    end
  end

  assign trig_ready  = trig_q;
  assign sin_out     = sin_out_q;
  assign cos_out     = cos_out_q;
  assign sweep_done  = done_q;
  assign req_overrun = overrun_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_goertzel_coeff_server.sv
module tb_goertzel_coeff_server;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       sys_rst;
  logic       request_trig;
  logic       trig_ready;
  logic [15:0] sin_out;
  logic [15:0] cos_out;
  logic [8:0] bin_start;
  logic [8:0] bin_step;
  logic [5:0] num_coeffs;
  logic       sweep_restart;
  logic       sweep_done;
  logic       req_overrun;
  logic [2:0] dbg_state;

  int cyc = 0;
  int n_total = 0;
  int n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  goertzel_coeff_server #(
    .NUM_SAMPLES (512),
    .NS_BITS     (9),
    .C_W         (16)
  ) dut (
    .sys_clk       (clk),
    .sys_rst       (sys_rst),
    .request_trig  (request_trig),
    .trig_ready    (trig_ready),
    .sin_out       (sin_out),
    .cos_out       (cos_out),
    .bin_start     (bin_start),
    .bin_step      (bin_step),
    .num_coeffs    (num_coeffs),
    .sweep_restart (sweep_restart),
    .sweep_done    (sweep_done),
    .req_overrun   (req_overrun),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] due;
    logic [7:0]  tol;
    logic        done;
    logic [15:0] s;
    logic [15:0] c;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    n_total++;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
  endtask

  task automatic push_exp(input int s, input int c, input bit done, input int tol, input int due);
    exp_t e;
    e.due  = 32'(due);
    e.tol  = 8'(tol);
    e.done = done;
    e.s    = 16'(s);
    e.c    = 16'(c);
    exp_q.push_back(e);
  endtask

  function automatic int model_sin(input int k);
    real a;
    a = 2.0 * 3.14159265358979 * k / 512.0;
    return $rtoi($floor(16384.0 * $sin(a) + 0.5));
  endfunction

  function automatic int model_cos(input int k);
    real a;
    a = 2.0 * 3.14159265358979 * k / 512.0;
    return $rtoi($floor(16384.0 * $cos(a) + 0.5));
  endfunction

  // Monitor: pops one expectation per trig_ready pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!sys_rst) begin
      if (trig_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_trig: trig_ready=1 with nothing expected at cycle %0d", cyc);
        end else begin
          e = exp_t'(exp_q.pop_front());
          check("latency", cyc, int'(e.due), 0);
          check("sin_out", $signed(sin_out), $signed(e.s), int'(e.tol));
          check("cos_out", $signed(cos_out), $signed(e.c), int'(e.tol));
          check("sweep_done", int'(sweep_done), int'(e.done), 0);
        end
      end else if (sweep_done) begin
        n_total++;
        $display("FAIL stray_done: sweep_done=1 without trig_ready at cycle %0d", cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart_pulse();
    tick();
    sweep_restart = 1'b1;
    tick();
    sweep_restart = 1'b0;
  endtask

  // One-cycle request; returns the cycle in which the edge is presented.
  task automatic request(output int issue);
    tick();
    request_trig = 1'b1;
    issue = cyc;
    tick();
    request_trig = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  task automatic single(input int b, input int s, input int c);
    int issue;
    bin_start  = 9'(b);
    bin_step   = 9'd0;
    num_coeffs = 6'd1;
    restart_pulse();
    request(issue);
    push_exp(s, c, 1'b1, 0, issue + 5);
    wait_drain();
  endtask

  task automatic do_reset();
    tick();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int issue;
    int n;
    int ks[5];
    bit dn[5];
    ks = '{10, 13, 16, 19, 10};
    dn = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    sys_rst       = 1'b1;
    request_trig  = 1'b0;
    sweep_restart = 1'b0;
    bin_start     = 9'd0;
    bin_step      = 9'd0;
    num_coeffs    = 6'd1;
    repeat (3) @(posedge clk);
    #1 sys_rst = 1'b0;

    @(negedge clk);
    check("rst_trig_ready", int'(trig_ready), 0, 0);
    check("rst_sin_out", int'(sin_out), 0, 0);
    check("rst_cos_out", int'(cos_out), 0, 0);
    check("rst_sweep_done", int'(sweep_done), 0, 0);
    check("rst_req_overrun", int'(req_overrun), 0, 0);
    check("rst_state", int'(dbg_state), 0, 0);

    // Directed quadrant/boundary bins.
    single(0, 0, 16384);
    single(128, 16384, 0);
    single(256, 0, -16384);
    single(64, 11585, 11585);
    single(448, -11585, 11585);

    // Sweep: start 10, step 3, 4 coefficients, then wrap.
    bin_start  = 9'd10;
    bin_step   = 9'd3;
    num_coeffs = 6'd4;
    restart_pulse();
    for (int i = 0; i < 5; i++) begin
      request(issue);
      push_exp(model_sin(ks[i]), model_cos(ks[i]), dn[i], 1, issue + 5);
      wait_drain();
    end

    // Back-to-back edges: second queued, third overruns.
    bin_start  = 9'd128;
    bin_step   = 9'd0;
    num_coeffs = 6'd1;
    restart_pulse();
    tick();
    request_trig = 1'b1;
    n = cyc;
    push_exp(16384, 0, 1'b1, 0, n + 5);
    tick();
    request_trig = 1'b0;
    tick();
    request_trig = 1'b1;
    push_exp(16384, 0, 1'b1, 0, n + 10);
    tick();
    request_trig = 1'b0;
    @(negedge clk);
    check("overrun_before_third", int'(req_overrun), 0, 0);
    tick();
    request_trig = 1'b1;
    tick();
    request_trig = 1'b0;
    wait_drain();
    repeat (3) tick();
    check("overrun_set", int'(req_overrun), 1, 0);
    do_reset();
    @(negedge clk);
    check("overrun_cleared", int'(req_overrun), 0, 0);

    // Reset while the request sits in S_DATA: abandoned, no trig_ready.
    bin_start = 9'd64;
    tick();
    request_trig = 1'b1;
    tick();
    request_trig = 1'b0;
    tick();
    sys_rst = 1'b1;
    @(negedge clk);
    check("state_at_reset", int'(dbg_state), 2, 0);
    tick();
    tick();
    sys_rst = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    check("abort_trig_ready", int'(trig_ready), 0, 0);
    check("abort_sin_out", int'(sin_out), 0, 0);
    check("abort_cos_out", int'(cos_out), 0, 0);
    check("abort_sweep_done", int'(sweep_done), 0, 0);
    request(issue);
    push_exp(11585, 11585, 1'b1, 0, issue + 5);
    wait_drain();

    // Full-circle sweep against the real-valued model; num_coeffs=0 acts as 1.
    num_coeffs = 6'd0;
    bin_step   = 9'd5;
    for (int b = 0; b < 512; b++) begin
      bin_start = 9'(b);
      restart_pulse();
      request(issue);
      push_exp(model_sin(b), model_cos(b), 1'b1, 1, issue + 5);
      wait_drain();
    end

    repeat (4) tick();
    check("queue_empty", exp_q.size(), 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
